// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG encoder front end.
//   PIX_PER_BLK  : pixels in one 8x8 block
//   ycc_tag_t    : per-pixel block/frame position flags
//   ycc_word_t   : one converter result plus its position flags
//   feed_state_t : feed controller FSM states
package jpeg_enc_pkg;

  localparam int PIX_PER_BLK = 64;

  typedef struct packed {
    logic first;
    logic last;
    logic frame_end;
  } ycc_tag_t;

  typedef struct packed {
    logic [23:0] ycc;
    ycc_tag_t    tag;
  } ycc_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : head entry, forced to 0 while empty
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push-when-full is fine then.
  assign do_push  = push && (!full || do_pop);
  assign count    = count_reg;
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The producer's credit scheme must never overrun the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop))
        else $error("sync_fifo: push while full without pop");
    end
  end

endmodule

// File: rtl/ycbcr_feed_ctrl.sv
// Feeds a fixed-latency RGB->YCbCr converter for one frame job of
// num_blocks 8x8 blocks and buffers its results for the DCT buffer.
//   start/num_blocks : job start (IDLE only), block count latched on start
//   busy/done        : job in progress / one-cycle completion pulse
//   in_*             : block-ordered RGB pixel stream (valid/ready)
//   cv_r/g/b, cv_ycc : converter inputs / converter output (CV_LAT later)
//   out_*            : YCbCr results with block/frame position flags
// The converter cannot stall, so pixels are only accepted when a FIFO
// slot is guaranteed for every result already in flight.
module ycbcr_feed_ctrl
  import jpeg_enc_pkg::*;
#(
  parameter int CV_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BLK_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_rgb,
  output logic [7:0]       cv_r,
  output logic [7:0]       cv_g,
  output logic [7:0]       cv_b,
  input  logic [23:0]      cv_ycc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_ycc,
  output logic             out_first,
  output logic             out_last,
  output logic             out_frame_end
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  feed_state_t      state_reg;
  logic [BLK_W-1:0] num_blocks_reg;
  logic [BLK_W-1:0] blk_cnt_reg;
  logic [5:0]       pix_cnt_reg;
  logic             done_reg;
  logic [CV_LAT-1:0] valid_pipe_reg;
  ycc_tag_t         tag_pipe_reg [CV_LAT];

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             accept;
  logic             pix_last;
  logic             blk_last;
  ycc_tag_t         acc_tag;
  ycc_word_t        push_word;
  ycc_word_t        head_word;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CV_LAT; i++) begin
      inflight = inflight + CNT_W'(valid_pipe_reg[i]);
    end
  end

  // Credit: results already in the pipe each own a future FIFO slot.
  assign in_ready = (state_reg == RUN) &&
                    (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C);
  assign accept   = in_valid && in_ready;

  assign cv_r = accept ? in_rgb[23:16] : 8'd0;
  assign cv_g = accept ? in_rgb[15:8]  : 8'd0;
  assign cv_b = accept ? in_rgb[7:0]   : 8'd0;

  assign pix_last          = (pix_cnt_reg == 6'(PIX_PER_BLK - 1));
  assign blk_last          = (blk_cnt_reg == num_blocks_reg - BLK_W'(1));
  assign acc_tag.first     = (pix_cnt_reg == 6'd0);
  assign acc_tag.last      = pix_last;
  assign acc_tag.frame_end = pix_last && blk_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_pipe_reg <= '0;
      for (int i = 0; i < CV_LAT; i++) tag_pipe_reg[i] <= '0;
    end else begin
      for (int i = CV_LAT - 1; i > 0; i--) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        tag_pipe_reg[i]   <= tag_pipe_reg[i-1];
      end
      valid_pipe_reg[0] <= accept;
      tag_pipe_reg[0]   <= acc_tag;
    end
  end

  assign push_word.ycc = cv_ycc;
  assign push_word.tag = tag_pipe_reg[CV_LAT-1];
  assign fifo_pop      = out_valid && out_ready;

  sync_fifo #(
    .WIDTH ($bits(ycc_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (valid_pipe_reg[CV_LAT-1]),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid     = !fifo_empty;
  assign out_ycc       = head_word.ycc;
  assign out_first     = head_word.tag.first;
  assign out_last      = head_word.tag.last;
  assign out_frame_end = head_word.tag.frame_end;

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      num_blocks_reg <= '0;
      blk_cnt_reg    <= '0;
      pix_cnt_reg    <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (num_blocks != '0) begin
              num_blocks_reg <= num_blocks;
              blk_cnt_reg    <= '0;
              pix_cnt_reg    <= '0;
              state_reg      <= RUN;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            pix_cnt_reg <= pix_cnt_reg + 6'd1;
            if (pix_last) begin
              blk_cnt_reg <= blk_cnt_reg + BLK_W'(1);
              if (blk_last) state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish in the cycle the final result leaves the FIFO, so done
          // follows the last pop by exactly one cycle.
          if (valid_pipe_reg == '0 &&
              (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop))) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr_feed_ctrl.sv
module tb_ycbcr_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] num_blocks = '0;
  logic        busy;
  logic        done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_rgb = '0;
  logic [7:0]  cv_r, cv_g, cv_b;
  logic [23:0] cv_ycc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_ycc;
  logic        out_first, out_last, out_frame_end;

  always #5 clk = ~clk;

  ycbcr_feed_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_blocks    (num_blocks),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rgb        (in_rgb),
    .cv_r          (cv_r),
    .cv_g          (cv_g),
    .cv_b          (cv_b),
    .cv_ycc        (cv_ycc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ycc       (out_ycc),
    .out_first     (out_first),
    .out_last      (out_last),
    .out_frame_end (out_frame_end)
  );

  // Integer BT.601 full-range approximation of the converter.
  function automatic logic [23:0] conv(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]);
    y  = (77*r + 150*g + 29*b) >>> 8;
    cb = ((-43*r - 85*g + 128*b) >>> 8) + 128;
    cr = ((128*r - 107*g - 21*b) >>> 8) + 128;
    if (y > 255) y = 255;
    if (cb < 0) cb = 0;
    if (cb > 255) cb = 255;
    if (cr < 0) cr = 0;
    if (cr > 255) cr = 255;
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  // Two-register converter model: input regs then output regs.
  logic [23:0] cv_s1 = '0;
  always @(posedge clk) begin
    cv_s1  <= {cv_r, cv_g, cv_b};
    cv_ycc <= conv(cv_s1);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int total = 0, cur_seed = 0, in_idx = 0, out_idx = 0;
  int done_cnt = 0, fe_cnt = 0, busy_gap = 0;
  int first_acc_cyc = -1, first_ov_cyc = -1, last_pop_cyc = 0, done_cyc = 0;
  bit job_active = 0;
  logic        s_in_ready, s_out_valid, s_done, s_busy;
  logic [23:0] s_out_ycc;
  logic [2:0]  s_flags;
  logic [23:0] cap [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input int seed, input int k);
    int r, g, b;
    if (seed == 0 && k == 0) return 24'hFF0000;
    if (seed == 0 && k == 1) return 24'h000000;
    if (seed == 0 && k == 2) return 24'hFFFFFF;
    r = (k*7 + seed) & 255;
    g = (k*13 + 3*seed + 3) & 255;
    b = (255 - k - seed) & 255;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    logic [23:0] y;
    y = conv(pix_rgb(cur_seed, k));
    return {5'b0, y, (k % 64) == 0, (k % 64) == 63, k == total - 1};
  endfunction

  // One clock cycle: sample and score at the falling edge, return after
  // the next rising edge so the caller can drive fresh inputs.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_done      = done;
    s_busy      = busy;
    s_out_ycc   = out_ycc;
    s_flags     = {out_first, out_last, out_frame_end};
    if (in_valid && in_ready) begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      in_idx++;
    end
    if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (out_valid === 1'b1 && out_ready) begin
      $display("out %0d ycc=%06h first=%0b last=%0b frame_end=%0b",
               out_idx, out_ycc, out_first, out_last, out_frame_end);
      if (out_idx >= total) begin
        check_eq("extra_out", out_idx, total - 1);
      end else begin
        check_eq("out_word", {5'b0, out_ycc, out_first, out_last, out_frame_end},
                 exp_word(out_idx));
      end
      if (out_idx < 3) cap[out_idx] = out_ycc;
      if (out_frame_end) fe_cnt++;
      out_idx++;
      last_pop_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (job_active) begin
      if (done === 1'b1) job_active = 0;
      else if (busy !== 1'b1) busy_gap++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int in_p, input int out_p);
    in_valid  = (in_idx < total) && ($urandom_range(0, 99) < in_p);
    in_rgb    = pix_rgb(cur_seed, in_idx);
    out_ready = ($urandom_range(0, 99) < out_p);
  endtask

  task automatic start_job(input int nb, input int seed);
    total = nb * 64; cur_seed = seed;
    in_idx = 0; out_idx = 0; done_cnt = 0; fe_cnt = 0; busy_gap = 0;
    first_acc_cyc = -1; first_ov_cyc = -1;
    in_valid = 1'b0;
    start = 1'b1;
    num_blocks = 12'(nb);
    cycle();
    start = 1'b0;
    job_active = (nb != 0);
  endtask

  task automatic finish_job(input int in_p, input int out_p);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      drive(in_p, out_p);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    check_eq("done_once", done_cnt, 1);
    check_eq("out_count", out_idx, total);
  endtask

  initial begin
    // Reset state
    repeat (3) cycle();
    check_eq("rst_busy", s_busy, 0);
    check_eq("rst_done", s_done, 0);
    check_eq("rst_in_ready", s_in_ready, 0);
    check_eq("rst_out_valid", s_out_valid, 0);
    check_eq("rst_out_ycc", s_out_ycc, 0);
    check_eq("rst_flags", s_flags, 0);
    rst = 1'b0;
    cycle();

    // 1+2: one block, full throughput, red/black/white lead pixels
    start_job(1, 0);
    finish_job(100, 100);
    check_eq("acc_to_valid", first_ov_cyc - first_acc_cyc, 3);
    check_eq("pop_to_done", done_cyc - last_pop_cyc, 1);
    check_eq("fe_count1", fe_cnt, 1);
    check_eq("red_ycc", cap[0], 24'h4C55FF);
    check_eq("black_ycc", cap[1], 24'h008080);
    check_eq("white_ycc", cap[2], 24'hFF8080);

    // 3: back-pressure fills the FIFO, then drains in order
    start_job(2, 5);
    for (int i = 0; i < 8; i++) begin
      drive(100, 0);
      cycle();
    end
    check_eq("bp_accepts", in_idx, 4);
    check_eq("bp_in_ready", s_in_ready, 0);
    check_eq("bp_out_valid", s_out_valid, 1);
    check_eq("bp_hold_a", s_out_ycc, conv(pix_rgb(5, 0)));
    drive(100, 0);
    cycle();
    drive(100, 0);
    cycle();
    check_eq("bp_hold_b", s_out_ycc, conv(pix_rgb(5, 0)));
    check_eq("bp_accepts2", in_idx, 4);
    finish_job(100, 100);

    // 4: two blocks, random handshakes
    start_job(2, 3);
    finish_job(70, 60);
    check_eq("fe_count2", fe_cnt, 1);
    check_eq("busy_gap", busy_gap, 0);

    // 5a: zero-block job, with a pixel offered while idle
    in_valid = 1'b1;
    in_rgb = 24'h123456;
    start_job(0, 7);
    in_valid = 1'b1;
    cycle();
    check_eq("zero_done", s_done, 1);
    check_eq("zero_busy", s_busy, 0);
    check_eq("idle_in_ready", s_in_ready, 0);
    cycle();
    check_eq("zero_done_pulse", s_done, 0);
    check_eq("zero_busy2", s_busy, 0);
    in_valid = 1'b0;

    // 5b: start during RUN is ignored
    start_job(1, 9);
    for (int i = 0; i < 10; i++) begin
      drive(100, 100);
      cycle();
    end
    start = 1'b1;
    num_blocks = 12'd3;
    drive(100, 100);
    cycle();
    start = 1'b0;
    finish_job(100, 100);
    check_eq("restart_fe", fe_cnt, 1);

    // 6: reset with results in flight, then a clean job
    start_job(2, 11);
    for (int i = 0; i < 20; i++) begin
      drive(100, 50);
      cycle();
    end
    rst = 1'b1;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    job_active = 0;
    cycle();
    check_eq("mid_rst_out_valid", s_out_valid, 0);
    check_eq("mid_rst_in_ready", s_in_ready, 0);
    check_eq("mid_rst_busy", s_busy, 0);
    check_eq("mid_rst_done", s_done, 0);
    check_eq("mid_rst_ycc", s_out_ycc, 0);
    check_eq("mid_rst_flags", s_flags, 0);
    rst = 1'b0;
    done_cnt = 0;
    out_ready = 1'b1;
    repeat (4) cycle();
    check_eq("post_rst_no_done", done_cnt, 0);
    check_eq("post_rst_empty", s_out_valid, 0);
    start_job(1, 13);
    finish_job(100, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
